// File: rtl/envelope_if.sv
`default_nettype none
// ============================================================================
// Module   : envelope_if
// Purpose  : Control, sample and status bundle of the ADSR envelope stage.
//            The master drives gate/enable, the ADSR rates, the sustain level
//            and the incoming channel sample. The slave returns the scaled
//            sample, the current envelope level and the busy flag.
// Signals  : ena, gate                : advance enable, note on/off
//            attack, decay, rel [R]   : cycles-per-step rate periods
//            sustain [E]              : sustain level
//            in [N]                   : channel sample, offset binary
//            out [N]                  : scaled sample, offset binary
//            level [E], busy          : envelope status
// Revision : 1.0 - initial release
// ============================================================================
interface envelope_if #(
  parameter int N = 10,
  parameter int E = 8,
  parameter int R = 16
);
  logic         ena;
  logic         gate;
  logic [R-1:0] attack;
  logic [R-1:0] decay;
  logic [E-1:0] sustain;
  logic [R-1:0] rel;
  logic [N-1:0] in;
  logic [N-1:0] out;
  logic [E-1:0] level;
  logic         busy;

  modport master (
    output ena, gate, attack, decay, sustain, rel, in,
    input  out, level, busy
  );

  modport slave (
    input  ena, gate, attack, decay, sustain, rel, in,
    output out, level, busy
  );
endinterface
`default_nettype wire

// File: rtl/envelope.sv
`default_nettype none
// ============================================================================
// Module   : envelope
// Purpose  : ADSR amplitude envelope. A gate-driven attack/decay/sustain/
//            release state machine produces an E-bit level; the offset-binary
//            channel sample is scaled about mid-scale by that level and
//            registered to the output.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous reset, active low
//            bus  - envelope_if.slave (controls, rates, sample in/out, status)
// Revision : 1.0 - initial release
// ============================================================================
module envelope #(
  parameter int N = 10,
  parameter int E = 8,
  parameter int R = 16
) (
  input  logic      clk,
  input  logic      rst,
  envelope_if.slave bus
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_attack  = 3'd1;
  localparam logic [2:0] c_st_decay   = 3'd2;
  localparam logic [2:0] c_st_sustain = 3'd3;
  localparam logic [2:0] c_st_release = 3'd4;

  localparam logic [E-1:0] c_lvl_max = '1;
  localparam logic [E-1:0] c_lvl_one = {{(E-1){1'b0}}, 1'b1};
  localparam logic [R-1:0] c_cnt_one = {{(R-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] c_mid     = {1'b1, {(N-1){1'b0}}};

  logic [2:0]   r_state;
  logic [R-1:0] r_cnt;
  logic [E-1:0] r_level;
  logic [N-1:0] r_out;

  logic [R-1:0] w_rate;
  logic         w_step;

  // ---------------------------------------------------------------------------
  // Rate selection. The compare is >= so that a rate lowered below the
  // running count produces a step on the very next enabled cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rate = '0;
    case (r_state)
      c_st_attack:  w_rate = bus.attack;
      c_st_decay:   w_rate = bus.decay;
      c_st_release: w_rate = bus.rel;
      default:      w_rate = '0;
    endcase
  end

  assign w_step = (r_cnt >= w_rate);

  // ---------------------------------------------------------------------------
  // Scaling: signed sample times unsigned level, floor-shifted back by E.
  // |q| <= |s| for any level, so the low N bits of q always hold the result.
  // ---------------------------------------------------------------------------
  logic signed [N-1:0] w_s;
  logic signed [N+E:0] w_s_ext;
  logic signed [N+E:0] w_l_ext;
  logic signed [N+E:0] w_p;
  logic signed [N+E:0] w_q;
  logic [N-1:0]        w_out;
  logic                w_unused_q;

  assign w_s        = {~bus.in[N-1], bus.in[N-2:0]};
  assign w_s_ext    = {{(E+1){w_s[N-1]}}, w_s};
  assign w_l_ext    = {{(N+1){1'b0}}, r_level};
  assign w_p        = w_s_ext * w_l_ext;
  assign w_q        = w_p >>> E;
  assign w_out      = {~w_q[N-1], w_q[N-2:0]};
  assign w_unused_q = ^w_q[N+E:N];

  // ---------------------------------------------------------------------------
  // Envelope state machine and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_level <= '0;
      r_out   <= c_mid;
    end else begin
      // Output scaling runs regardless of ena.
      r_out <= w_out;

      if (bus.ena) begin
        case (r_state)
          c_st_idle: begin
            if (bus.gate) begin
              r_state <= c_st_attack;
              r_cnt   <= '0;
            end
          end

          c_st_attack: begin
            // The step is applied even when the gate drops on the same
            // cycle, so an attack completing together with gate-off still
            // lands on full scale before release begins.
            if (w_step) begin
              r_cnt <= '0;
              if (r_level != c_lvl_max)
                r_level <= r_level + c_lvl_one;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end

            if (!bus.gate) begin
              r_state <= c_st_release;
              r_cnt   <= '0;
            end else if (w_step && (r_level >= c_lvl_max - c_lvl_one)) begin
              r_state <= c_st_decay;
            end
          end

          c_st_decay: begin
            if (!bus.gate) begin
              r_state <= c_st_release;
              r_cnt   <= '0;
            end else if (r_level <= bus.sustain) begin
              r_state <= c_st_sustain;
              r_cnt   <= '0;
            end else if (w_step) begin
              r_level <= r_level - c_lvl_one;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end

          c_st_sustain: begin
            // Level follows sustain live, including on the gate-off cycle.
            r_level <= bus.sustain;
            if (!bus.gate) begin
              r_state <= c_st_release;
              r_cnt   <= '0;
            end
          end

          c_st_release: begin
            // Retrigger resumes the attack from wherever the level is now.
            if (bus.gate) begin
              r_state <= c_st_attack;
              r_cnt   <= '0;
            end else if (r_level == '0) begin
              r_state <= c_st_idle;
              r_cnt   <= '0;
            end else if (w_step) begin
              r_level <= r_level - c_lvl_one;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end

          default: begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_level <= '0;
          end
        endcase
      end
    end
  end

  assign bus.out   = r_out;
  assign bus.level = r_level;
  assign bus.busy  = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_envelope.sv
`default_nettype none
// ============================================================================
// Module   : tb_envelope
// Purpose  : Self-checking bench for envelope. A behavioural ADSR model is
//            advanced on every clock edge and pushes the expected level, busy
//            and output sample into a scoreboard queue; an independent
//            monitor pops and compares one entry after every edge. Directed
//            ADSR, scaling and boundary sequences are followed by randomized
//            gate/enable/rate/reset traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_envelope;

  localparam int N = 10;
  localparam int E = 8;
  localparam int R = 16;
  localparam int LMAX = (1 << E) - 1;
  localparam int MID  = 1 << (N - 1);

  localparam int PH_IDLE = 0;
  localparam int PH_ATK  = 1;
  localparam int PH_DEC  = 2;
  localparam int PH_SUS  = 3;
  localparam int PH_REL  = 4;

  typedef struct {
    int lvl;
    int busy;
    int out;
  } exp_t;

  logic clk;
  logic rst;

  envelope_if #(.N(N), .E(E), .R(R)) bus ();

  envelope #(.N(N), .E(E), .R(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Behavioural model state
  int m_phase = PH_IDLE;
  int m_level = 0;
  int m_cnt   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Floor of s*level/2^E mapped back to offset binary.
  function automatic int scale(input int in_code, input int lvl);
    int s;
    int p;
    int q;
    s = in_code - MID;
    p = s * lvl;
    if (p >= 0) q = p / (1 << E);
    else        q = -((-p + (1 << E) - 1) / (1 << E));
    return q + MID;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    exp_t e;
    int   old_level;
    int   rate;
    bit   due;
    old_level = m_level;
    if (!rst) begin
      m_phase = PH_IDLE;
      m_level = 0;
      m_cnt   = 0;
      e.out   = MID;
    end else begin
      e.out = scale(int'(bus.in), old_level);
      if (bus.ena) begin
        rate = (m_phase == PH_ATK) ? int'(bus.attack) :
               (m_phase == PH_DEC) ? int'(bus.decay)  : int'(bus.rel);
        due  = (m_cnt >= rate);
        if (m_phase == PH_IDLE) begin
          if (bus.gate) begin m_phase = PH_ATK; m_cnt = 0; end
        end else if (m_phase == PH_ATK) begin
          if (due) begin
            m_level = (m_level < LMAX) ? m_level + 1 : LMAX;
            m_cnt = 0;
          end else m_cnt++;
          if (!bus.gate) begin m_phase = PH_REL; m_cnt = 0; end
          else if (due && m_level == LMAX) m_phase = PH_DEC;
        end else if (m_phase == PH_DEC) begin
          if (!bus.gate) begin m_phase = PH_REL; m_cnt = 0; end
          else if (m_level <= int'(bus.sustain)) begin m_phase = PH_SUS; m_cnt = 0; end
          else if (due) begin m_level--; m_cnt = 0; end
          else m_cnt++;
        end else if (m_phase == PH_SUS) begin
          m_level = int'(bus.sustain);
          if (!bus.gate) begin m_phase = PH_REL; m_cnt = 0; end
        end else begin
          if (bus.gate) begin m_phase = PH_ATK; m_cnt = 0; end
          else if (m_level == 0) begin m_phase = PH_IDLE; m_cnt = 0; end
          else if (due) begin m_level--; m_cnt = 0; end
          else m_cnt++;
        end
      end
    end
    e.lvl  = m_level;
    e.busy = (m_phase != PH_IDLE) ? 1 : 0;
    sb.push_back(e);
  endtask

  // One clock: inputs already set at the falling edge; returns at next fall.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in = 10'($urandom_range(0, (1 << N) - 1));
      cyc();
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation after each edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("sb_level", int'(bus.level), mon_e.lvl);
      check("sb_busy",  int'(bus.busy),  mon_e.busy);
      check("sb_out",   int'(bus.out),   mon_e.out);
    end
  end

  initial begin
    rst         = 1'b0;
    bus.ena     = 1'b1;
    bus.gate    = 1'b1;
    bus.attack  = 16'd0;
    bus.decay   = 16'd1;
    bus.sustain = 8'd128;
    bus.rel     = 16'd3;
    bus.in      = 10'd1023;
    @(negedge clk);

    // Reset held with full-scale input and gate high
    for (int i = 0; i < 4; i++) cyc();
    check("rst_out",   int'(bus.out),   MID);
    check("rst_level", int'(bus.level), 0);
    check("rst_busy",  int'(bus.busy),  0);

    // Attack 0 -> 255 at one step per cycle
    rst = 1'b1;
    bus.in = 10'd700;
    cyc();
    check("busy_after_gate", int'(bus.busy), 1);
    run(255);
    check("attack_peak", int'(bus.level), 255);

    // Scaling at full level
    bus.in = 10'd1023;
    cyc();
    check("scale_255_max", int'(bus.out), 1021);
    bus.in = 10'd0;
    cyc();
    check("scale_255_min", int'(bus.out), 2);

    // Decay to sustain 128 (254 cycles after the peak in total)
    run(252);
    check("decay_to_sustain", int'(bus.level), 128);
    bus.in = 10'd1023;
    cyc();
    check("scale_128_max", int'(bus.out), 767);
    run(20);
    check("sustain_hold", int'(bus.level), 128);

    // Release at rel=3: 28 steps of 4 cycles reach 100
    bus.gate = 1'b0;
    cyc();
    run(112);
    check("release_at_100", int'(bus.level), 100);

    // Retrigger resumes attack from 100
    bus.gate   = 1'b1;
    bus.attack = 16'd2;
    cyc();
    run(30);
    check("retrigger_level", int'(bus.level), 110);

    // Release all the way to IDLE
    bus.gate = 1'b0;
    bus.rel  = 16'd0;
    run(300);
    check("idle_level", int'(bus.level), 0);
    check("idle_busy",  int'(bus.busy),  0);
    bus.in = 10'd1000;
    cyc();
    check("scale_level0", int'(bus.out), MID);

    // Enable hold mid-attack
    bus.gate   = 1'b1;
    bus.attack = 16'd3;
    run(21);
    bus.ena = 1'b0;
    run(50);
    check("ena_hold_level", int'(bus.level), 5);
    bus.ena = 1'b1;
    run(30);
    bus.gate = 1'b0;
    run(300);

    // sustain = 255: decay lasts a single cycle
    bus.sustain = 8'd255;
    bus.attack  = 16'd0;
    bus.gate    = 1'b1;
    run(300);
    check("sustain_max", int'(bus.level), 255);
    bus.gate = 1'b0;
    run(300);

    // Lower attack rate from 1000 to 5 while cnt = 500
    bus.attack = 16'd1000;
    bus.gate   = 1'b1;
    cyc();
    run(500);
    check("slow_attack_flat", int'(bus.level), 0);
    bus.attack = 16'd5;
    cyc();
    check("rate_lower_step", int'(bus.level), 1);
    run(40);

    // Reset asserted mid-release takes effect immediately
    bus.gate = 1'b0;
    bus.rel  = 16'd10;
    run(15);
    rst = 1'b0;
    #1;
    check("async_rst_level", int'(bus.level), 0);
    check("async_rst_busy",  int'(bus.busy),  0);
    check("async_rst_out",   int'(bus.out),   MID);
    run(3);
    rst = 1'b1;

    // Randomized traffic
    bus.sustain = 8'd60;
    bus.attack  = 16'd1;
    bus.decay   = 16'd2;
    bus.rel     = 16'd1;
    for (int i = 0; i < 4000; i++) begin
      bus.ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) bus.gate = ~bus.gate;
      if ($urandom_range(0, 149) == 0) begin
        bus.attack = 16'($urandom_range(0, 7));
        bus.decay  = 16'($urandom_range(0, 7));
        bus.rel    = 16'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.sustain = 8'd0;
          1:       bus.sustain = 8'd255;
          default: bus.sustain = 8'($urandom_range(0, 255));
        endcase
      end
      rst = ($urandom_range(0, 499) != 0);
      bus.in = 10'($urandom_range(0, (1 << N) - 1));
      cyc();
    end
    rst = 1'b1;
    run(2);

    @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/envelope.md
# envelope

Amplitude envelope (ADSR) stage that sits directly downstream of `channel`. It takes the channel's N-bit offset-binary waveform sample and scales it about mid-scale by an E-bit envelope level. The level is driven by a gate-controlled attack/decay/sustain/release state machine. Its output feeds the mixer/DAC path in the same offset-binary format the channel produces.

## Interface
- `N`, 10: sample width; must match the channel's `N`.
- `E`, 8: envelope level width; full scale is 2^E-1.
- `R`, 16: rate input width (cycles-per-step counter).

- `clk` input 1: system clock, rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `ena` input 1: envelope advance enable; when low, state, rate counter and level hold.
- `gate` input 1: note on (1) / note off (0), sampled every clock.
- `attack` input R: attack step period; level changes by one every `attack`+1 enabled cycles.
- `decay` input R: decay step period, same encoding.
- `sustain` input E: sustain level.
- `rel` input R: release step period, same encoding.
- `in` input N: channel sample, offset binary; 2^(N-1) is silence.
- `out` output N: scaled sample, offset binary.
- `level` output E: current envelope level.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Rate counter `cnt` (R bits):
  - Counts enabled cycles in ATTACK, DECAY and RELEASE.
  - When `cnt >= rate` of the current phase, the level steps by one and `cnt` clears.
  - The compare is `>=`, so lowering the rate mid-phase causes a step on the next enabled cycle.
  - `cnt` clears on every state transition.
- Transitions (only when `ena`=1; when `ena`=0 nothing changes):
  - IDLE: `gate`=1 → ATTACK. Level stays 0.
  - ATTACK:
    - `gate`=0 → RELEASE.
    - Otherwise the level increments on each step. On the step that reaches 2^E-1 → DECAY.
  - DECAY:
    - `gate`=0 → RELEASE.
    - Else if `level <= sustain` → SUSTAIN, with no step that cycle.
    - Else the level decrements on each step.
  - SUSTAIN:
    - `level` is loaded with `sustain` every cycle, so it tracks live changes.
    - `gate`=0 → RELEASE.
  - RELEASE:
    - `gate`=1 → ATTACK, starting from the current level (no reset to 0).
    - Else if `level`==0 → IDLE.
    - Else the level decrements on each step.
- `gate` held high in ATTACK/DECAY/SUSTAIN has no retrigger effect (legato).
- Level never wraps: saturates at 0 and 2^E-1.
- Scaling arithmetic, every cycle, independent of `ena`:
  - `s` = `in` with its MSB inverted, read as N-bit signed.
  - `p` = `s` × {0,`level`}, computed as (N+E+1)-bit signed.
  - `q` = `p` >>> E (arithmetic shift, floor).
  - `out` = `q[N-1:0]` with its MSB inverted.
  - `|q| <= |s|`, so no overflow and no clipping logic is needed.

## Timing
- Reset values: state IDLE, `cnt`=0, `level`=0, `busy`=0, `out`=2^(N-1) (512 at N=10).
- Reset may assert at any time; all registers return to these values immediately, with no completion of the in-flight step.
- `gate` rise in IDLE → `busy`=1 one cycle later.
- First level step in ATTACK occurs `attack`+1 enabled cycles after entering the state.
- Full attack 0→2^E-1 takes (2^E-1)·(`attack`+1) enabled cycles; with `attack`=0 the level rises by 1 per cycle.
- `out` is registered: one-cycle latency from `in`/`level` to `out`.
- `level` output is the registered level, and is the value used for the next `out`.
- Edge values of `sustain`:
  - `sustain`=2^E-1: DECAY lasts exactly one cycle, then SUSTAIN.
  - `sustain`=0: SUSTAIN holds at 0 with `busy`=1. Gate-off → RELEASE → IDLE on the next enabled cycle.
- Simultaneous events: gate-off on the same cycle as the ATTACK-completing step takes precedence → RELEASE, but the level still updates to 2^E-1.

## Test plan
- Reset: `rst`=0 with `in`=1023, `gate`=1 → `out`=512, `level`=0, `busy`=0. Release reset → ATTACK begins.
- Attack/decay/sustain (N=10, E=8): `attack`=0, `decay`=1, `sustain`=128, `gate`=1 → `level`=255 after 255 cycles, then 128 after a further 254 cycles, then holds in SUSTAIN.
- Scaling: `level`=255, `in`=1023 → `out`=1021. `in`=0 → `out`=2. `level`=128, `in`=1023 → `out`=767. `level`=0 → `out`=512.
- Release and retrigger:
  - From SUSTAIN at 128 with `rel`=3, drop `gate` → level decrements every 4 cycles.
  - Raise `gate` at `level`=100 → ATTACK resumes from 100.
  - Later `gate`=0 → reaches 0 → IDLE, `busy`=0.
- Enable hold: `ena`=0 for 50 cycles mid-attack → `level` and `cnt` frozen, `out` still tracks `in`. Re-enable → stepping resumes with the remaining count.
- Boundaries:
  - `sustain`=255 → DECAY lasts one cycle.
  - Lower `attack` from 1000 to 5 when `cnt`=500 → step on the next cycle.
  - Assert reset mid-release → immediate return to reset values.
